// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store accesses onto one RAM; define MEM_ARB_RR_EN for round-robin grant
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_mask,
  output logic                ls_ack,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                err,
  output logic                mem_request,
  output logic                mem_w_en,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic win_ls;
  logic grant_ls;
  logic [CW-1:0] cnt;
`ifdef MEM_ARB_RR_EN
  logic prio_ls;
  assign grant_ls = ls_req && (!if_req || prio_ls);
  // priority flips to the other port on every grant
  always_ff @(posedge clk) begin
    if (rst) prio_ls <= 1'b1;
    else if (state == IDLE && (if_req || ls_req)) prio_ls <= !grant_ls;
  end
`else
  assign grant_ls = ls_req;
`endif
  // single-transaction FSM with registered RAM and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      win_ls      <= 1'b0;
      cnt         <= '0;
      if_ack      <= 1'b0;
      ls_ack      <= 1'b0;
      err         <= 1'b0;
      if_rdata    <= '0;
      ls_rdata    <= '0;
      mem_request <= 1'b0;
      mem_w_en    <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_mask    <= '0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: if (if_req || ls_req) begin
          win_ls      <= grant_ls;
          mem_request <= 1'b1;
          mem_w_en    <= grant_ls && ls_we;
          mem_address <= grant_ls ? ls_addr : if_addr;
          mem_wdata   <= grant_ls ? ls_wdata : '0;
          mem_mask    <= grant_ls ? ls_mask : '1;
          state       <= ISSUE;
        end
        ISSUE: begin
          mem_request <= 1'b0;
          mem_w_en    <= 1'b0;
          cnt         <= '0;
          state       <= WAIT;
        end
        WAIT: if (mem_valid || cnt == LAST) begin
          if_ack <= !win_ls;
          ls_ack <= win_ls;
          err    <= !mem_valid;
          if (win_ls) ls_rdata <= mem_valid ? mem_rdata : '0;
          else if_rdata <= mem_valid ? mem_rdata : '0;
          state  <= RESP;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
